// File: rtl/dp32_accum.sv
// dp32_accum: sequential accumulator behind the dp32 SIMD dot-product unit.
// Each job picks one dp32 result per vector by the latched precision mode,
// zero-extends it, sums it over `len` vectors and holds the total in DONE
// until the consumer accepts it. All outputs are registers or state decodes.
module dp32_accum #(
    parameter int ACC_W = 72,   // must be >= 64 to hold one int32 product
    parameter int LEN_W = 8
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       mul_int32,
    input  logic [32:0]       sum_int16,
    input  logic [17:0]       sum_int8,
    input  logic [10:0]       sum_int4,
    input  logic [7:0]        sum_int2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [2:0]        out_mode,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] MODE_INT32 = 3'd0;
    localparam logic [2:0] MODE_INT16 = 3'd1;
    localparam logic [2:0] MODE_INT8  = 3'd2;
    localparam logic [2:0] MODE_INT4  = 3'd3;
    localparam logic [2:0] MODE_INT2  = 3'd4;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         mode_q;
    logic [LEN_W-1:0]   remaining;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [ACC_W-1:0]   term;
    logic [ACC_W:0]     sum;
    logic               start_ok;
    logic               accept;
    logic               last;

    // Reserved modes (5..7) make start a no-op, so they never leave IDLE.
    assign start_ok = (state == IDLE) && start && (mode <= MODE_INT2);
    assign accept   = (state == ACC) && in_valid;
    assign last     = accept && (remaining == LEN_W'(1));

    // Pick the dp32 result for the latched precision and zero-extend it.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        term = '0;
        case (mode_q)
            MODE_INT32: term = ACC_W'(mul_int32);
            MODE_INT16: term = ACC_W'(sum_int16);
            MODE_INT8:  term = ACC_W'(sum_int8);
            MODE_INT4:  term = ACC_W'(sum_int4);
            MODE_INT2:  term = ACC_W'(sum_int2);
            default:    term = '0;
        endcase
    end

    // One extra bit captures the carry out of the accumulator's MSB.
    assign sum = {1'b0, acc} + {1'b0, term};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job datapath: latch the job on start, accumulate on each accepted vector.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            mode_q    <= '0;
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (start_ok) begin
            mode_q    <= mode;
            remaining <= len;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            acc       <= sum[ACC_W-1:0];
            ovf       <= ovf | sum[ACC_W];
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign acc_out   = acc;
    assign out_mode  = mode_q;
    assign overflow  = ovf;

endmodule

// File: tb/tb_dp32_accum.sv
// Scoreboard bench for dp32_accum: stimulus pushes the hand-computed total of
// each job into a queue; a monitor pops and compares on every output handshake.
// A second instance with ACC_W = 64 sees the same stimulus to exercise wrap.
module tb_dp32_accum;

    logic        CLK;
    logic        nrst;
    logic        start;
    logic [2:0]  mode;
    logic [7:0]  len;
    logic        in_valid;
    logic [63:0] mul_int32;
    logic [32:0] sum_int16;
    logic [17:0] sum_int8;
    logic [10:0] sum_int4;
    logic [7:0]  sum_int2;
    logic        out_ready;

    logic        in_ready,  in_ready64;
    logic        out_valid, out_valid64;
    logic [71:0] acc_out;
    logic [63:0] acc_out64;
    logic [2:0]  out_mode,  out_mode64;
    logic        overflow,  overflow64;
    logic        busy,      busy64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [71:0] acc;
        logic [2:0]  mode;
        logic        ovf;
    } exp_t;

    exp_t q72[$];
    exp_t q64[$];

    dp32_accum #(.ACC_W(72), .LEN_W(8)) dut (
        .CLK(CLK), .nrst(nrst), .start(start), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .mul_int32(mul_int32), .sum_int16(sum_int16), .sum_int8(sum_int8),
        .sum_int4(sum_int4), .sum_int2(sum_int2),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .out_mode(out_mode), .overflow(overflow), .busy(busy)
    );

    dp32_accum #(.ACC_W(64), .LEN_W(8)) dut64 (
        .CLK(CLK), .nrst(nrst), .start(start), .mode(mode), .len(len),
        .in_valid(in_valid), .in_ready(in_ready64),
        .mul_int32(mul_int32), .sum_int16(sum_int16), .sum_int8(sum_int8),
        .sum_int4(sum_int4), .sum_int2(sum_int2),
        .out_valid(out_valid64), .out_ready(out_ready), .acc_out(acc_out64),
        .out_mode(out_mode64), .overflow(overflow64), .busy(busy64)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [71:0] a72, input logic [71:0] a64,
                        input logic [2:0] m, input logic o72, input logic o64);
        exp_t e;
        e.acc = a72; e.mode = m; e.ovf = o72;
        q72.push_back(e);
        e.acc = a64; e.mode = m; e.ovf = o64;
        q64.push_back(e);
    endtask

    // Monitor: compare each handshaken result against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (nrst && out_valid && out_ready) begin
            if (q72.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out72: got acc 0x%0h, expected no output", acc_out);
            end else begin
                e = q72.pop_front();
                check("acc72",  acc_out, e.acc);
                check("mode72", 72'(out_mode), 72'(e.mode));
                check("ovf72",  72'(overflow), 72'(e.ovf));
            end
        end
        if (nrst && out_valid64 && out_ready) begin
            if (q64.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out64: got acc 0x%0h, expected no output", acc_out64);
            end else begin
                e = q64.pop_front();
                check("acc64",  72'(acc_out64), e.acc);
                check("mode64", 72'(out_mode64), 72'(e.mode));
                check("ovf64",  72'(overflow64), 72'(e.ovf));
            end
        end
    end

    task automatic do_start(input logic [2:0] m, input logic [7:0] l);
        @(posedge CLK); #1;
        start = 1'b1; mode = m; len = l;
        @(posedge CLK); #1;
        start = 1'b0; mode = 3'($urandom); len = 8'($urandom);
    endtask

    // One cycle of dp32 inputs; non-selected fields carry random garbage.
    task automatic drive_vec(input logic v, input logic [2:0] m, input logic [63:0] val);
        in_valid  = v;
        mul_int32 = {$urandom, $urandom};
        sum_int16 = 33'({$urandom, $urandom});
        sum_int8  = 18'($urandom);
        sum_int4  = 11'($urandom);
        sum_int2  = 8'($urandom);
        case (m)
            3'd0:    mul_int32 = val;
            3'd1:    sum_int16 = val[32:0];
            3'd2:    sum_int8  = val[17:0];
            3'd3:    sum_int4  = val[10:0];
            default: sum_int2  = val[7:0];
        endcase
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || busy64) && n < 30) begin
            @(posedge CLK); #1;
            n++;
        end
        if (busy || busy64) begin
            total++; bad++;
            $display("FAIL %s: got busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  72'(in_ready),  72'd0);
        check({tag, "_out_valid"}, 72'(out_valid), 72'd0);
        check({tag, "_busy"},      72'(busy),      72'd0);
        check({tag, "_overflow"},  72'(overflow),  72'd0);
        check({tag, "_acc_out"},   acc_out,        72'd0);
        check({tag, "_out_mode"},  72'(out_mode),  72'd0);
        check({tag, "_overflow64"}, 72'(overflow64), 72'd0);
        check({tag, "_acc_out64"},  72'(acc_out64),  72'd0);
    endtask

    initial begin
        logic [6:0] pat;

        nrst = 1'b0; start = 1'b0; mode = '0; len = '0; in_valid = 1'b0;
        mul_int32 = '0; sum_int16 = '0; sum_int8 = '0; sum_int4 = '0; sum_int2 = '0;
        out_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        nrst = 1'b1;

        // int2, len 3, 16 per vector, in_valid held high.
        push(72'd48, 72'd48, 3'd4, 1'b0, 1'b0);
        do_start(3'd4, 8'd3);
        check("in_ready_after_start", 72'(in_ready), 72'd1);
        for (int i = 0; i < 3; i++) begin
            drive_vec(1'b1, 3'd4, 64'd16);
        end
        check("int2_out_valid_latency", 72'(out_valid), 72'd1);
        wait_idle("int2_idle");

        // int32, len 2: 72-bit total fits, 64-bit instance wraps and overflows.
        push(72'h1_FFFF_FFFC_0000_0002, 72'h0_FFFF_FFFC_0000_0002, 3'd0, 1'b0, 1'b1);
        do_start(3'd0, 8'd2);
        for (int i = 0; i < 2; i++) begin
            drive_vec(1'b1, 3'd0, 64'hFFFF_FFFE_0000_0001);
        end
        wait_idle("int32_idle");

        // int8, len 4, in_valid pattern 1,0,0,1,1,0,1.
        push(72'd18496, 72'd18496, 3'd2, 1'b0, 1'b0);
        do_start(3'd2, 8'd4);
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            drive_vec(pat[i], 3'd2, 64'd4624);
            if (i == 5) begin
                check("int8_partial_acc", acc_out, 72'd13872);
                check("int8_not_early", 72'(out_valid), 72'd0);
            end
        end
        check("int8_out_valid", 72'(out_valid), 72'd1);
        wait_idle("int8_idle");

        // Backpressure in DONE with a start pulse that must be ignored.
        out_ready = 1'b0;
        push(72'h1_FFFF_FFFF_FFFF_FFFE, 72'h0_FFFF_FFFF_FFFF_FFFE, 3'd0, 1'b0, 1'b1);
        do_start(3'd0, 8'd2);
        for (int i = 0; i < 2; i++) begin
            drive_vec(1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            mode  = 3'd2;
            len   = 8'd1;
            @(posedge CLK); #1;
            check("bp_acc_stable", acc_out, 72'h1_FFFF_FFFF_FFFF_FFFE);
            check("bp_out_valid", 72'(out_valid), 72'd1);
        end
        start = 1'b0;
        check("bp_mode_kept", 72'(out_mode), 72'd0);
        out_ready = 1'b1;
        wait_idle("bp_idle");

        // Fresh job after the overflowing one: overflow must be cleared.
        push(72'd200, 72'd200, 3'd3, 1'b0, 1'b0);
        do_start(3'd3, 8'd2);
        check("ovf64_cleared", 72'(overflow64), 72'd0);
        for (int i = 0; i < 2; i++) begin
            drive_vec(1'b1, 3'd3, 64'd100);
        end
        wait_idle("int4_idle");

        // len = 0: output one edge after start, total zero.
        push(72'd0, 72'd0, 3'd1, 1'b0, 1'b0);
        do_start(3'd1, 8'd0);
        check("len0_out_valid", 72'(out_valid), 72'd1);
        check("len0_acc", acc_out, 72'd0);
        wait_idle("len0_idle");

        // Reserved mode: ignored, no register changes.
        do_start(3'd6, 8'd5);
        check("rsv_busy", 72'(busy), 72'd0);
        check("rsv_in_ready", 72'(in_ready), 72'd0);
        check("rsv_out_mode", 72'(out_mode), 72'd1);
        @(posedge CLK); #1;
        check("rsv_busy_later", 72'(busy), 72'd0);

        // Asynchronous reset after 2 of 5 int4 vectors.
        do_start(3'd3, 8'd5);
        for (int i = 0; i < 2; i++) begin
            drive_vec(1'b1, 3'd3, 64'd7);
        end
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge CLK); #1;
        nrst = 1'b1;

        push(72'd9, 72'd9, 3'd3, 1'b0, 1'b0);
        do_start(3'd3, 8'd1);
        check("post_reset_acc_clear", acc_out, 72'd0);
        drive_vec(1'b1, 3'd3, 64'd9);
        wait_idle("post_reset_idle");

        @(posedge CLK); #1;
        check("q72_drained", 72'(q72.size()), 72'd0);
        check("q64_drained", 72'(q64.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dp32_accum.md
# dp32_accum

Sequential accumulator directly downstream of the combinational `dp32` SIMD dot-product unit. Once per job it selects one `dp32` result according to a latched precision mode and zero-extends it. It sums that result over a programmed number of vectors, then holds the total until a consumer accepts it. Both sides use valid/ready handshakes, so `dp32` operands can be streamed from an operand buffer at any rate.

## Interface
- `ACC_W`, default 72: accumulator width; must be ≥ 64 (int32 product width).
- `LEN_W`, default 8: width of the vector-count field.
- `CLK` in 1: clock; all state updates on the rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `start` in 1: job-start pulse; sampled only in IDLE.
- `mode` in 3: precision select, sampled with `start`: 0 = int32, 1 = int16, 2 = int8, 3 = int4, 4 = int2; 5–7 are reserved.
- `len` in LEN_W: number of vectors to accumulate, sampled with `start`.
- `in_valid` in 1: the `dp32` result inputs hold a valid vector.
- `in_ready` out 1: block accepts a vector this cycle.
- `mul_int32` in 64, `sum_int16` in 33, `sum_int8` in 18, `sum_int4` in 11, `sum_int2` in 8: unsigned `dp32` outputs.
- `out_valid` out 1: `acc_out` holds a finished total.
- `out_ready` in 1: consumer accepts the total.
- `acc_out` out ACC_W: accumulated total, unsigned.
- `out_mode` out 3: mode of the finished job.
- `overflow` out 1: sticky per job; set if any addition carried out of ACC_W.
- `busy` out 1: high whenever the block is not in IDLE.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `in_ready` = 0, `out_valid` = 0.
  - On `start` with a legal mode: latch `mode` and `len`, clear the accumulator and `overflow`, and load the remaining count with `len`.
  - If `len` = 0, go to DONE; otherwise go to ACC.
  - `start` with a reserved mode is ignored: the block stays in IDLE and no register changes.
- ACC:
  - `in_ready` = 1.
  - A vector is accepted on an edge where `in_valid && in_ready`.
  - On acceptance, the selected term (chosen by the latched mode) is zero-extended to ACC_W and added to the accumulator, and the remaining count decrements.
  - When the count reaches 0, go to DONE.
  - Cycles with `in_valid` = 0 change nothing.
- DONE:
  - `out_valid` = 1; `acc_out`, `out_mode` and `overflow` are held stable.
  - On `out_valid && out_ready`, go to IDLE.
- Arithmetic:
  - Additions are unsigned modulo 2^ACC_W.
  - A carry out of bit ACC_W-1 sets `overflow`, which stays set until the next accepted `start`.
  - All `dp32` terms are unsigned.
- `start` while `busy` is ignored and does not alter the latched mode or len.
- Input fields of the non-selected modes are don't-care.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`, `out_valid`, `busy`, `overflow` = 0.
  - `acc_out` = 0, `out_mode` = 0.
- Every output comes directly from a register or is decoded from the state only; there is no combinational path from inputs to outputs.
- `in_ready` goes high the cycle after the edge that accepted `start`.
- If the last vector is accepted at edge k, `out_valid` is high from edge k onward. Latency is one edge.
- A `len` = 0 job gives `out_valid` one edge after `start`, with `acc_out` = 0.
- Throughput is one vector per cycle in ACC; with no gaps, a job of N vectors occupies N+2 cycles from start to output acceptance.
- After the output handshake at edge m, the block is in IDLE and accepts a new `start` at edge m+1.
- Asserting `nrst` at any time, including mid-ACC or mid-DONE, immediately aborts the job and returns all state to reset values. A partial total is never presented.

## Test plan
- Reset, then int2 job with `len`=3 and a=b=0x55555555, so `sum_int2`=16 per vector, `in_valid` held high -> `out_valid` one edge after the 3rd acceptance, `acc_out`=48, `out_mode`=4, `overflow`=0.
- int32 job with `len`=2 and a=b=0xFFFFFFFF (`mul_int32`=0xFFFFFFFE00000001) -> `acc_out`=0x1_FFFFFFFC_00000002.
  - Repeat with `ACC_W`=64 -> `acc_out`=0xFFFFFFFC00000002 and `overflow`=1.
- int8 job with `len`=4 and a=b=0x22222222 (`sum_int8`=4624), `in_valid` toggled 1,0,0,1,1,0,1 -> exactly 4 acceptances, `acc_out`=18496, with no accumulation on gap cycles.
- Output backpressure: hold `out_ready`=0 for 5 cycles in DONE and pulse `start` with mode 2 -> `acc_out` stable and `start` ignored; after `out_ready`=1, IDLE follows, and the next `start` runs a fresh job with `overflow` cleared.
- Edge cases:
  - `len`=0 -> `out_valid` after 1 edge with `acc_out`=0.
  - `start` with `mode`=6 -> block stays in IDLE with `busy`=0.
- Drop `nrst` after 2 of 5 int4 vectors have been accepted -> all outputs return to reset values asynchronously, `out_valid` never asserts, and the next job starts from 0.
